// File: rtl/ami_wfeed_pkg.sv
// ami_pkg: shared definitions for the AXI master write-feed slice.
//   - default bus geometry (AXI_DW, AXI_AW, BL) and the derived widths L and B
//   - wfeed_state_e : job FSM states (IDLE, RUN, DONE)
//   - lane_mask()   : byte-lane strobe mask, either from a lane upward or up to a lane
package ami_pkg;

  localparam int AXI_DW    = 128;
  localparam int AXI_AW    = 32;
  localparam int BL        = 16;
  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int B         = $clog2(BL) + L;

  // Widest lane count lane_mask() can describe (1024-bit bus); callers
  // size-cast the result down to their own AXI_BYTES.
  localparam int MAX_LANES = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wfeed_state_e;

  typedef enum logic {
    MASK_LO = 1'b0,   // ones from lane 'off' upward
    MASK_HI = 1'b1    // ones from lane 0 up to and including lane 'off'
  } mask_dir_e;

  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [6:0] off,
                                                     input mask_dir_e dir);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (dir == MASK_LO) m[i] = (i >= int'(off));
      else                m[i] = (i <= int'(off));
    end
    return m;
  endfunction

endpackage

// File: rtl/ami_wfeed_if.sv
// ami_wfeed_if: bundles the job-config, source-beat, W-stream and job-status
// signals of ami_wfeed.
//   master modport : the feed block (accepts jobs and source beats, drives W)
//   slave modport  : the surrounding environment (requester, source, W sink)
interface ami_wfeed_if #(
  parameter int AXI_DW = ami_pkg::AXI_DW
);
  localparam int AXI_BYTES = AXI_DW / 8;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [31:0]          cfg_sa;
  logic [31:0]          cfg_len;

  logic [AXI_DW-1:0]    src_data;
  logic [AXI_BYTES-1:0] src_strb;
  logic                 src_valid;
  logic                 src_ready;

  logic [AXI_DW-1:0]    usr_wdata;
  logic [AXI_BYTES-1:0] usr_wstrb;
  logic                 usr_wlast;
  logic                 usr_wvalid;
  logic                 usr_wready;

  logic                 job_done;
  logic                 job_err;

  modport master (
    input  cfg_valid, cfg_sa, cfg_len,
    input  src_data, src_strb, src_valid,
    input  usr_wready,
    output cfg_ready, src_ready,
    output usr_wdata, usr_wstrb, usr_wlast, usr_wvalid,
    output job_done, job_err
  );

  modport slave (
    output cfg_valid, cfg_sa, cfg_len,
    output src_data, src_strb, src_valid,
    output usr_wready,
    input  cfg_ready, src_ready,
    input  usr_wdata, usr_wstrb, usr_wlast, usr_wvalid,
    input  job_done, job_err
  );

endinterface

// File: rtl/ami_wfeed_skid.sv
// ami_wfeed_skid: 2-entry register slice used on the W side when
// AMI_WFEED_SKID_EN is defined.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready is a register,
//                           high while at most one entry is held)
//   in_data               : {wdata, wstrb, wlast}
//   out_valid/out_ready   : downstream handshake, out_data from a register
//   empty                 : no entry held
module ami_wfeed_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  logic [W-1:0] ent0, ent1;   // ent0 is always the head
  logic [1:0]   cnt, cnt_n;
  logic         ready_q, valid_q;
  logic         push, pop;

  assign push = in_valid && ready_q;
  assign pop  = valid_q && out_ready;

  always_comb begin
    cnt_n = cnt + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0    <= '0;
      ent1    <= '0;
      cnt     <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // A new beat goes straight to the head when the head is free (or is
      // being drained with nothing behind it); otherwise it queues in ent1.
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) ent0 <= in_data;
      else if (pop)                                        ent0 <= ent1;
      if (push && cnt == 2'd1 && !pop)                     ent1 <= in_data;
      cnt     <= cnt_n;
      valid_q <= (cnt_n != 2'd0);
      ready_q <= (cnt_n <= 2'd1);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = ent0;
  assign empty     = !valid_q;

endmodule

// File: rtl/ami_wfeed.sv
// ami_wfeed: turns a lane-aligned source beat stream into the user W stream
// for one DMA write job at a time.  Trims strobes on the partial first and
// last beats and raises usr_wlast at the end of every BL-beat aligned window
// and at the end of the job.
//   usr_clk, usr_reset_n : clock, async active-low reset
//   bus (master)         : cfg_* job request, src_* source beats,
//                          usr_w* W stream, job_done/job_err status
// Build option: AMI_WFEED_SKID_EN inserts a 2-entry register slice on the W
// outputs (1-cycle latency, registered src_ready); without it the source is
// passed through combinationally.
module ami_wfeed
  import ami_pkg::*;
#(
  parameter int AXI_DW = ami_pkg::AXI_DW,
  parameter int AXI_AW = ami_pkg::AXI_AW,
  parameter int BL     = ami_pkg::BL
) (
  input logic         usr_clk,
  input logic         usr_reset_n,
  ami_wfeed_if.master bus
);

  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int B         = $clog2(BL) + L;

  wfeed_state_e         state;
  logic                 cfg_ready_q, done_q, err_q;
  logic [32:0]          cur_addr, end_addr;
  logic [L-1:0]         first_off;
  logic                 first_beat;

  logic                 run, final_beat, take;
  logic [32:0]          sum, limit;
  logic [AXI_BYTES-1:0] lo_mask, hi_mask, beat_strb;
  logic                 beat_last;

  assign run        = (state == RUN);
  assign sum        = {1'b0, bus.cfg_sa} + {1'b0, bus.cfg_len};
  assign limit      = 33'd1 << AXI_AW;
  assign final_beat = (cur_addr[32:L] == end_addr[32:L]);

  assign lo_mask   = first_beat ? AXI_BYTES'(lane_mask(7'(first_off), MASK_LO)) : '1;
  assign hi_mask   = final_beat ? AXI_BYTES'(lane_mask(7'(end_addr[L-1:0]), MASK_HI)) : '1;
  assign beat_strb = bus.src_strb & lo_mask & hi_mask;
  assign beat_last = final_beat || (&cur_addr[B-1:L]);

`ifdef AMI_WFEED_SKID_EN
  // Once the final beat is in the slice, stop taking source beats and wait
  // for the slice to drain before declaring the job done.
  logic                           final_taken;
  logic                           skid_in_ready, skid_empty, skid_out_valid;
  logic [AXI_DW+AXI_BYTES:0]      skid_out;

  assign take          = run && !final_taken && bus.src_valid && skid_in_ready;
  assign bus.src_ready = run && !final_taken && skid_in_ready;

  ami_wfeed_skid #(.W(AXI_DW + AXI_BYTES + 1)) u_skid (
    .clk       (usr_clk),
    .rst_n     (usr_reset_n),
    .in_valid  (run && !final_taken && bus.src_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({bus.src_data, beat_strb, beat_last}),
    .out_valid (skid_out_valid),
    .out_ready (bus.usr_wready),
    .out_data  (skid_out),
    .empty     (skid_empty)
  );

  assign bus.usr_wvalid = skid_out_valid;
  assign bus.usr_wdata  = skid_out[AXI_DW+AXI_BYTES:AXI_BYTES+1];
  assign bus.usr_wstrb  = skid_out[AXI_BYTES:1];
  assign bus.usr_wlast  = skid_out[0];
`else
  assign take           = run && bus.src_valid && bus.usr_wready;
  assign bus.src_ready  = run && bus.usr_wready;
  assign bus.usr_wvalid = run && bus.src_valid;
  assign bus.usr_wdata  = run ? bus.src_data : '0;
  assign bus.usr_wstrb  = run ? beat_strb : '0;
  assign bus.usr_wlast  = run && beat_last;
`endif

  // Job FSM.  cur_addr walks the beat-aligned addresses of the job; the
  // final beat is the one whose beat address matches that of end_addr.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state       <= IDLE;
      cfg_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cur_addr    <= '0;
      end_addr    <= '0;
      first_off   <= '0;
      first_beat  <= 1'b0;
`ifdef AMI_WFEED_SKID_EN
      final_taken <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            cur_addr    <= {1'b0, bus.cfg_sa[31:L], {L{1'b0}}};
            first_off   <= bus.cfg_sa[L-1:0];
            end_addr    <= sum - 33'd1;
            first_beat  <= 1'b1;
            cfg_ready_q <= 1'b0;
            if (bus.cfg_len == 32'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b0;
            end else if (sum > limit) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (take) begin
            cur_addr   <= cur_addr + 33'(AXI_BYTES);
            first_beat <= 1'b0;
`ifdef AMI_WFEED_SKID_EN
            if (final_beat) final_taken <= 1'b1;
`else
            if (final_beat) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b0;
            end
`endif
          end
`ifdef AMI_WFEED_SKID_EN
          if (final_taken && skid_empty) begin
            final_taken <= 1'b0;
            state       <= DONE;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
          end
`endif
        end
        DONE: begin
          state       <= IDLE;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          cfg_ready_q <= 1'b1;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.job_done  = done_q;
  assign bus.job_err   = err_q;

endmodule

// File: tb/tb_ami_wfeed.sv
// tb_ami_wfeed: directed self-checking bench for ami_wfeed (AXI_DW=128,
// BL=16, 256-byte windows).  Works in both the pass-through and the
// AMI_WFEED_SKID_EN build.
module tb_ami_wfeed;

  localparam int DW = 128;

  logic usr_clk = 1'b0;
  logic usr_reset_n = 1'b0;

  always #5 usr_clk = ~usr_clk;

  ami_wfeed_if #(.AXI_DW(DW)) bus ();

  ami_wfeed #(.AXI_DW(DW), .AXI_AW(32), .BL(16)) dut (
    .usr_clk     (usr_clk),
    .usr_reset_n (usr_reset_n),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] obs_data [64];
  logic [15:0]  obs_strb [64];
  logic [63:0]  obs_last;
  int           obs_count;
  int           wvalid_cycles;
  bit           done_seen;
  logic         err_seen;
  int           last_w_cyc, done_cyc;

`ifdef AMI_WFEED_SKID_EN
  localparam int DONE_LAG = 2;
`else
  localparam int DONE_LAG = 1;
`endif

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'h0100_0000};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one job and plays n_src source beats into it, recording every W
  // handshake.  Inputs change and outputs are sampled 1 ns after the falling
  // edge.  abort_at >= 0 pulls reset low once that many W beats are seen.
  task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] len,
                               input int n_src, input bit rand_en,
                               input int abort_at);
    int src_idx;
    int cyc;
    bit sv;
    obs_count = 0; obs_last = '0; wvalid_cycles = 0;
    done_seen = 0; err_seen = 1'b0; last_w_cyc = -1; done_cyc = -1;
    src_idx = 0; sv = 0; cyc = 0;
    @(negedge usr_clk);
    bus.cfg_sa = sa; bus.cfg_len = len; bus.cfg_valid = 1'b1;
    while (!done_seen && cyc < 3000) begin
      @(negedge usr_clk);
      cyc++;
      bus.cfg_valid = 1'b0;
      if (!sv && src_idx < n_src) sv = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.src_valid  = sv;
      bus.src_data   = pat(src_idx);
      bus.src_strb   = '1;
      bus.usr_wready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (bus.usr_wvalid) wvalid_cycles++;
      if (bus.usr_wvalid && bus.usr_wready) begin
        if (obs_count < 64) begin
          obs_data[obs_count] = bus.usr_wdata;
          obs_strb[obs_count] = bus.usr_wstrb;
          obs_last[obs_count] = bus.usr_wlast;
        end
        obs_count++;
        last_w_cyc = cyc;
      end
      if (bus.src_valid && bus.src_ready) begin
        src_idx++;
        sv = 0;
      end
      if (bus.job_done) begin
        done_seen = 1;
        err_seen  = bus.job_err;
        done_cyc  = cyc;
      end
      if (abort_at >= 0 && obs_count == abort_at) begin
        usr_reset_n = 1'b0;
        #1;
        break;
      end
    end
    bus.src_valid = 1'b0;
    if (abort_at < 0) checkOutput("job_done_seen", 128'(done_seen), 128'd1);
  endtask

  task automatic checkFullJob(input string tag);
    checkOutput({tag, "_count"}, 128'(obs_count), 128'd32);
    checkOutput({tag, "_wlast"}, 128'(obs_last), 128'h0000_0000_8000_8000);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), obs_data[i], pat(i));
      checkOutput($sformatf("%s_strb%0d", tag, i), 128'(obs_strb[i]), 128'hFFFF);
    end
    checkOutput({tag, "_err"}, 128'(err_seen), 128'd0);
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_sa = '0; bus.cfg_len = '0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.src_strb = '0;
    bus.usr_wready = 1'b0;
    usr_reset_n = 1'b0;
    repeat (3) @(negedge usr_clk);
    checkOutput("rst_cfg_ready", 128'(bus.cfg_ready), 128'd1);
    checkOutput("rst_src_ready", 128'(bus.src_ready), 128'd0);
    checkOutput("rst_wvalid", 128'(bus.usr_wvalid), 128'd0);
    checkOutput("rst_wstrb", 128'(bus.usr_wstrb), 128'd0);
    checkOutput("rst_job_done", 128'(bus.job_done), 128'd0);
    checkOutput("rst_job_err", 128'(bus.job_err), 128'd0);
    usr_reset_n = 1'b1;
    @(negedge usr_clk);

    // Aligned 512-byte job: two full 16-beat bursts.
    applyStimulus(32'h1000, 32'd512, 32, 1'b0, -1);
    checkFullJob("t1");
    checkOutput("t1_done_lag", 128'(done_cyc - last_w_cyc), 128'(DONE_LAG));
    @(negedge usr_clk); #1;
    checkOutput("t1_done_pulse", 128'(bus.job_done), 128'd0);

    // Unaligned start and end inside one window.
    applyStimulus(32'h1003, 32'd20, 2, 1'b0, -1);
    checkOutput("t2_count", 128'(obs_count), 128'd2);
    checkOutput("t2_strb0", 128'(obs_strb[0]), 128'hFFF8);
    checkOutput("t2_strb1", 128'(obs_strb[1]), 128'h007F);
    checkOutput("t2_wlast", 128'(obs_last), 128'h2);
    checkOutput("t2_data1", obs_data[1], pat(1));

    // Job straddling a window boundary: both beats close a burst.
    applyStimulus(32'h10F8, 32'd16, 2, 1'b0, -1);
    checkOutput("t3_count", 128'(obs_count), 128'd2);
    checkOutput("t3_strb0", 128'(obs_strb[0]), 128'hFF00);
    checkOutput("t3_strb1", 128'(obs_strb[1]), 128'h00FF);
    checkOutput("t3_wlast", 128'(obs_last), 128'h3);

    // Zero-length job, then a job running past the 4 GiB boundary.
    applyStimulus(32'h2000, 32'd0, 0, 1'b0, -1);
    checkOutput("t4a_wvalid", 128'(wvalid_cycles), 128'd0);
    checkOutput("t4a_err", 128'(err_seen), 128'd0);
    applyStimulus(32'hFFFF_FFF0, 32'd32, 2, 1'b0, -1);
    checkOutput("t4b_wvalid", 128'(wvalid_cycles), 128'd0);
    checkOutput("t4b_err", 128'(err_seen), 128'd1);

    // Same as the first job with random source gaps and W back-pressure.
    applyStimulus(32'h1000, 32'd512, 32, 1'b1, -1);
    checkFullJob("t5");

    // Reset in the middle of a job, then a clean rerun.
    applyStimulus(32'h1000, 32'd512, 32, 1'b0, 5);
    checkOutput("t6_rst_wvalid", 128'(bus.usr_wvalid), 128'd0);
    checkOutput("t6_rst_wlast", 128'(bus.usr_wlast), 128'd0);
    checkOutput("t6_rst_wstrb", 128'(bus.usr_wstrb), 128'd0);
    checkOutput("t6_rst_wdata", bus.usr_wdata, 128'd0);
    checkOutput("t6_rst_src_ready", 128'(bus.src_ready), 128'd0);
    checkOutput("t6_rst_cfg_ready", 128'(bus.cfg_ready), 128'd1);
    checkOutput("t6_rst_job_done", 128'(bus.job_done), 128'd0);
    repeat (2) @(negedge usr_clk);
    usr_reset_n = 1'b1;
    @(negedge usr_clk);
    applyStimulus(32'h1000, 32'd512, 32, 1'b0, -1);
    checkFullJob("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ami_wfeed.md
Name: ami_wfeed

Overview:
- Upstream stage of the AXI master write path: converts a raw lane-aligned data stream into the user W stream (wdata/wstrb/wlast) consumed by the AXI master write interface.
- Per DMA write job (start address, byte length), it generates byte strobes for the partial first and last beats.
- It asserts wlast on exactly the beats where the address partitioner closes a burst: the end of each BL-beat aligned window, or the end of the job.
- Sits in the usr_clk domain between the user data source and the write interface's usr_w port.

Parameters:
- AXI_DW, 128, data bus width in bits
- AXI_AW, 32, address width (≤32)
- BL, 16, burst-window length in beats; must match the partitioner
- AXI_BYTES, AXI_DW/8, bytes per beat (derived)
- L, $clog2(AXI_BYTES), byte-offset bits (derived)
- B, $clog2(BL)+L, burst-window address bits (derived)

Ports:
- usr_clk  in  1  clock
- usr_reset_n  in  1  reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  job accept
- cfg_sa  in  32  job start byte address
- cfg_len  in  32  job length in bytes
- src_data  in  AXI_DW  source beat, byte lane = address mod AXI_BYTES
- src_strb  in  AXI_BYTES  source byte enables
- src_valid  in  1  source beat valid
- src_ready  out  1  source beat accept
- usr_wdata  out  AXI_DW  W data to write interface
- usr_wstrb  out  AXI_BYTES  W strobe
- usr_wlast  out  1  last beat of burst
- usr_wvalid  out  1  W valid
- usr_wready  in  1  W ready
- job_done  out  1  one-cycle pulse at end of job
- job_err  out  1  qualifies job_done: job rejected

Behaviour:
- Clock and reset: one clock, usr_clk. Reset usr_reset_n is asynchronous and active-low.
- Reset values: state IDLE; cfg_ready=1; src_ready=0; usr_wvalid=0; usr_wlast=0; usr_wstrb=0; usr_wdata=0; job_done=0; job_err=0. All counters and registers are 0.
- FSM IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch cur_addr = {cfg_sa[31:L], L'b0}, first_off = cfg_sa[L-1:0], and end_addr = cfg_sa+cfg_len-1 (33-bit arithmetic).
  - cfg_len==0 → DONE (no beats).
  - cfg_sa+cfg_len > 2^32 → DONE with err.
  - Otherwise → RUN.
- FSM RUN:
  - cfg_ready=0.
  - usr_wvalid = src_valid; src_ready = usr_wready. Zero latency, combinational pass-through of data/valid/ready.
  - usr_wstrb = src_strb & lo_mask & hi_mask.
    - lo_mask = ones from lane first_off upward, first beat only; all ones otherwise.
    - hi_mask = ones up to lane end_addr[L-1:0], final beat only; all ones otherwise.
  - usr_wlast = final beat OR cur_addr[B-1:L] all ones.
  - On handshake: cur_addr += AXI_BYTES. On the final beat (cur_addr[32:L]==end_addr[32:L]) → DONE.
- FSM DONE: job_done=1 for one cycle, job_err as latched; → IDLE. cfg_ready=0 in DONE.
- The next job can be accepted on the cycle after DONE; back-to-back jobs incur 2 idle cycles.
- Beat count per job = (first_off+len+AXI_BYTES-1)>>L. Exactly that many W handshakes occur.
- Source beats are never dropped or duplicated under arbitrary src_valid/usr_wready patterns.
- usr_wvalid, once asserted, stays with stable data until usr_wready. This is the source's obligation; the block adds no storage in base build.
- cfg_valid during RUN/DONE is ignored; cfg_sa/cfg_len are held by the requester until accepted.
- Reset mid-job: immediate return to IDLE. The partial burst is abandoned; the W interface must be reset together.

Optional Feature:
- Macro AMI_WFEED_SKID_EN.
- Defined: a 2-entry skid buffer on usr_w* outputs.
  - usr_w* are driven from registers.
  - src_ready is registered: asserted when the buffer holds ≤1 entry.
  - Latency is 1 cycle from source to W; full throughput is sustained.
  - DONE is entered only after the final beat leaves the buffer.
- Undefined: combinational pass-through as above.

Decomposition:
- Shared package ami_pkg: AXI_DW/AXI_AW/BL/L/B defaults; typedef wfeed_state_e {IDLE,RUN,DONE}; strobe-mask function lane_mask(off, dir).
- One sub-module, ami_wfeed_skid (2-entry register slice), instantiated only under AMI_WFEED_SKID_EN.

Test Plan (AXI_DW=128, BL=16, window 256 B):
1. sa=0x1000 len=512, src all strb 0xFFFF, wready=1 → 32 beats, wlast on beats 16 and 32, all wstrb 0xFFFF, job_done one cycle after beat 32, job_err=0.
2. sa=0x1003 len=20 → 2 beats: beat0 wstrb 0xFFF8 wlast=0; beat1 wstrb 0x007F wlast=1.
3. sa=0x10F8 len=16 → beat 0x10F0 wstrb 0xFF00 wlast=1; beat 0x1100 wstrb 0x00FF wlast=1.
4. len=0, then sa=0xFFFFFFF0 len=32 → each: no wvalid, job_done pulse; job_err=0 then 1.
5. Case 1 with random usr_wready and src_valid gaps (50%) → 32 beats in order, data matches source, wlast positions unchanged; repeat with AMI_WFEED_SKID_EN.
6. usr_reset_n low at beat 5 of case 1 → outputs at reset values same cycle; a new job after release runs cleanly from beat 0.
